// File: rtl/hazard_tracker.sv
// Hazard and forwarding unit for the 5-stage MIPS pipeline: shadows the E/M/W
// writers with their remaining Tnew and derives the D-stage stall plus D/E forwarding selects.
module hazard_tracker #(
   parameter int CNT_W = 32
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             valid_D,
   input  logic [4:0]       rs_D,
   input  logic [4:0]       rt_D,
   input  logic [1:0]       tuse_rs_D,
   input  logic [1:0]       tuse_rt_D,
   input  logic [1:0]       tnew_D,
   input  logic             regwrite_D,
   input  logic [4:0]       waddr_D,
   output logic             stall,
   output logic [1:0]       fwd_rs_D,
   output logic [1:0]       fwd_rt_D,
   output logic [1:0]       fwd_rs_E,
   output logic [1:0]       fwd_rt_E,
   output logic [CNT_W-1:0] stall_cnt
);

   logic       e_vld, m_vld, w_vld;
   logic [4:0] e_waddr, m_waddr, w_waddr;
   logic [1:0] e_tnew, m_tnew, w_tnew;
   logic [4:0] e_rs, e_rt;

   logic e_wr_rs, e_wr_rt, m_wr_rs, m_wr_rt, w_wr_rs, w_wr_rt;
   logic m_wr_ers, m_wr_ert, w_wr_ers, w_wr_ert;
   logic stall_rs, stall_rt, enter_e;

   function automatic logic writes(input logic vld, input logic [4:0] waddr, input logic [4:0] r);
      return vld && (waddr == r) && (r != 5'd0);
   endfunction

   // Nearest matching stage wins; if its result is not ready yet, fall back to the regfile
   // rather than an older (stale) stage.
   function automatic logic [1:0] sel_d(input logic e_hit, input logic [1:0] e_t,
                                        input logic m_hit, input logic [1:0] m_t,
                                        input logic w_hit, input logic [1:0] w_t);
      if (e_hit)      return (e_t == 2'd0) ? 2'd1 : 2'd0;
      else if (m_hit) return (m_t == 2'd0) ? 2'd2 : 2'd0;
      else if (w_hit) return (w_t == 2'd0) ? 2'd3 : 2'd0;
      else            return 2'd0;
   endfunction

   assign e_wr_rs  = writes(e_vld, e_waddr, rs_D);
   assign e_wr_rt  = writes(e_vld, e_waddr, rt_D);
   assign m_wr_rs  = writes(m_vld, m_waddr, rs_D);
   assign m_wr_rt  = writes(m_vld, m_waddr, rt_D);
   assign w_wr_rs  = writes(w_vld, w_waddr, rs_D);
   assign w_wr_rt  = writes(w_vld, w_waddr, rt_D);
   assign m_wr_ers = writes(m_vld, m_waddr, e_rs);
   assign m_wr_ert = writes(m_vld, m_waddr, e_rt);
   assign w_wr_ers = writes(w_vld, w_waddr, e_rs);
   assign w_wr_ert = writes(w_vld, w_waddr, e_rt);

   assign stall_rs = valid_D && (rs_D != 5'd0) &&
                     ((e_wr_rs && (tuse_rs_D < e_tnew)) || (m_wr_rs && (tuse_rs_D < m_tnew)));
   assign stall_rt = valid_D && (rt_D != 5'd0) &&
                     ((e_wr_rt && (tuse_rt_D < e_tnew)) || (m_wr_rt && (tuse_rt_D < m_tnew)));
   assign stall    = stall_rs || stall_rt;

   assign enter_e  = valid_D && !stall && regwrite_D && (waddr_D != 5'd0);

   assign fwd_rs_D = sel_d(e_wr_rs, e_tnew, m_wr_rs, m_tnew, w_wr_rs, w_tnew);
   assign fwd_rt_D = sel_d(e_wr_rt, e_tnew, m_wr_rt, m_tnew, w_wr_rt, w_tnew);
   assign fwd_rs_E = sel_d(1'b0, 2'd0, m_wr_ers, m_tnew, w_wr_ers, w_tnew);
   assign fwd_rt_E = sel_d(1'b0, 2'd0, m_wr_ert, m_tnew, w_wr_ert, w_tnew);

   // Non-writers still record rs/rt in E so the E-stage forwarding can see their operands.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         e_vld     <= 1'b0;
         e_waddr   <= 5'd0;
         e_tnew    <= 2'd0;
         e_rs      <= 5'd0;
         e_rt      <= 5'd0;
         m_vld     <= 1'b0;
         m_waddr   <= 5'd0;
         m_tnew    <= 2'd0;
         w_vld     <= 1'b0;
         w_waddr   <= 5'd0;
         w_tnew    <= 2'd0;
         stall_cnt <= '0;
      end else begin
         e_vld   <= enter_e;
         e_waddr <= enter_e ? waddr_D : 5'd0;
         e_tnew  <= enter_e ? tnew_D : 2'd0;
         e_rs    <= (valid_D && !stall) ? rs_D : 5'd0;
         e_rt    <= (valid_D && !stall) ? rt_D : 5'd0;
         m_vld   <= e_vld;
         m_waddr <= e_waddr;
         m_tnew  <= (e_tnew == 2'd0) ? 2'd0 : e_tnew - 2'd1;
         w_vld   <= m_vld;
         w_waddr <= m_waddr;
         w_tnew  <= 2'd0;
         if (stall)
            stall_cnt <= stall_cnt + {{(CNT_W-1){1'b0}}, 1'b1};
      end
   end

endmodule

// File: tb/tb_hazard_tracker.sv
// Scoreboard bench for hazard_tracker: each directed D-stage vector pushes its
// hand-computed outputs; a monitor pops and compares once per cycle.
module tb_hazard_tracker;

   logic        clk = 1'b0;
   logic        rst_n;
   logic        valid_D;
   logic [4:0]  rs_D, rt_D, waddr_D;
   logic [1:0]  tuse_rs_D, tuse_rt_D, tnew_D;
   logic        regwrite_D;
   logic        stall;
   logic [1:0]  fwd_rs_D, fwd_rt_D, fwd_rs_E, fwd_rt_E;
   logic [31:0] stall_cnt;

   typedef struct {
      string       name;
      logic        stall;
      logic [1:0]  frs_d, frt_d, frs_e, frt_e;
      logic [31:0] cnt;
   } exp_t;

   exp_t exp_q[$];
   int   checks = 0;
   int   errors = 0;

   hazard_tracker #(.CNT_W(32)) dut (
      .clk(clk), .rst_n(rst_n), .valid_D(valid_D), .rs_D(rs_D), .rt_D(rt_D),
      .tuse_rs_D(tuse_rs_D), .tuse_rt_D(tuse_rt_D), .tnew_D(tnew_D),
      .regwrite_D(regwrite_D), .waddr_D(waddr_D), .stall(stall),
      .fwd_rs_D(fwd_rs_D), .fwd_rt_D(fwd_rt_D), .fwd_rs_E(fwd_rs_E),
      .fwd_rt_E(fwd_rt_E), .stall_cnt(stall_cnt)
   );

   always #5 clk = ~clk;

   // One vector per cycle: drive at negedge and queue the outputs expected before the next posedge.
   task automatic applyStimulus(input string name, input logic rst, input logic v,
                                input logic [4:0] rs, input logic [4:0] rt,
                                input logic [1:0] urs, input logic [1:0] urt, input logic [1:0] tn,
                                input logic rw, input logic [4:0] wa,
                                input logic e_stall, input logic [1:0] e_frsd, input logic [1:0] e_frtd,
                                input logic [1:0] e_frse, input logic [1:0] e_frte, input logic [31:0] e_cnt);
      exp_t e;
      @(negedge clk);
      rst_n = rst; valid_D = v; rs_D = rs; rt_D = rt; tuse_rs_D = urs; tuse_rt_D = urt;
      tnew_D = tn; regwrite_D = rw; waddr_D = wa;
      e.name = name; e.stall = e_stall; e.frs_d = e_frsd; e.frt_d = e_frtd;
      e.frs_e = e_frse; e.frt_e = e_frte; e.cnt = e_cnt;
      exp_q.push_back(e);
   endtask

   task automatic idle(input string name, input logic [1:0] e_frse, input logic [1:0] e_frte,
                       input logic [31:0] e_cnt);
      applyStimulus(name, 1'b1, 1'b0, 5'd0, 5'd0, 2'd3, 2'd3, 2'd0, 1'b0, 5'd0,
                    1'b0, 2'd0, 2'd0, e_frse, e_frte, e_cnt);
   endtask

   task automatic cmp(input string name, input string field, input logic [31:0] act, input logic [31:0] req);
      checks++;
      if (act !== req) begin
         errors++;
         $display("[TB] FAIL %s.%s actual=%0d required=%0d", name, field, act, req);
      end
   endtask

   task automatic checkOutput(input exp_t e);
      cmp(e.name, "stall", {31'd0, stall}, {31'd0, e.stall});
      cmp(e.name, "fwd_rs_D", {30'd0, fwd_rs_D}, {30'd0, e.frs_d});
      cmp(e.name, "fwd_rt_D", {30'd0, fwd_rt_D}, {30'd0, e.frt_d});
      cmp(e.name, "fwd_rs_E", {30'd0, fwd_rs_E}, {30'd0, e.frs_e});
      cmp(e.name, "fwd_rt_E", {30'd0, fwd_rt_E}, {30'd0, e.frt_e});
      cmp(e.name, "stall_cnt", stall_cnt, e.cnt);
   endtask

   // Monitor: outputs are valid every cycle, so sample 2 time units after each negedge.
   initial begin
      forever begin
         @(negedge clk);
         #2;
         if (exp_q.size() > 0) checkOutput(exp_q.pop_front());
         if (rst_n && ((dut.m_vld && dut.m_waddr == dut.e_rs && dut.e_rs != 5'd0 && dut.m_tnew != 2'd0) ||
                       (dut.m_vld && dut.m_waddr == dut.e_rt && dut.e_rt != 5'd0 && dut.m_tnew != 2'd0))) begin
            errors++;
            $display("[TB] FAIL illegal_m_pending actual=1 required=0");
         end
      end
   end

   initial begin
      rst_n = 1'b0; valid_D = 1'b0; rs_D = 5'd0; rt_D = 5'd0; tuse_rs_D = 2'd3; tuse_rt_D = 2'd3;
      tnew_D = 2'd0; regwrite_D = 1'b0; waddr_D = 5'd0;
      repeat (2) @(posedge clk);
      $display("[TB] starting directed vectors");

      idle("reset", 2'd0, 2'd0, 32'd0);
      // add $3 then add $4,$3,$3: E-stage forward from M
      applyStimulus("add3", 1, 1, 5'd1, 5'd2, 2'd1, 2'd1, 2'd1, 1, 5'd3, 0, 0, 0, 0, 0, 32'd0);
      applyStimulus("add4", 1, 1, 5'd3, 5'd3, 2'd1, 2'd1, 2'd1, 1, 5'd4, 0, 0, 0, 0, 0, 32'd0);
      idle("add4_E", 2'd2, 2'd2, 32'd0);
      idle("drain1a", 2'd0, 2'd0, 32'd0);
      idle("drain1b", 2'd0, 2'd0, 32'd0);
      // lw $5 then beq $5,$0: two stall cycles, released with W forwarding
      applyStimulus("lw5", 1, 1, 5'd2, 5'd5, 2'd1, 2'd3, 2'd2, 1, 5'd5, 0, 0, 0, 0, 0, 32'd0);
      applyStimulus("beq_s1", 1, 1, 5'd5, 5'd0, 2'd0, 2'd0, 2'd0, 0, 5'd0, 1, 0, 0, 0, 0, 32'd0);
      applyStimulus("beq_s2", 1, 1, 5'd5, 5'd0, 2'd0, 2'd0, 2'd0, 0, 5'd0, 1, 0, 0, 0, 0, 32'd1);
      applyStimulus("beq_go", 1, 1, 5'd5, 5'd0, 2'd0, 2'd0, 2'd0, 0, 5'd0, 0, 3, 0, 0, 0, 32'd2);
      idle("beq_E", 2'd0, 2'd0, 32'd2);
      // jal then jr $31: forward from E with tnew 0
      applyStimulus("jal", 1, 1, 5'd0, 5'd0, 2'd3, 2'd3, 2'd0, 1, 5'd31, 0, 0, 0, 0, 0, 32'd2);
      applyStimulus("jr", 1, 1, 5'd31, 5'd0, 2'd0, 2'd3, 2'd0, 0, 5'd0, 0, 1, 0, 0, 0, 32'd2);
      idle("jr_E", 2'd2, 2'd0, 32'd2);
      idle("drain3", 2'd0, 2'd0, 32'd2);
      // ori $6 / lw $6 / sw: nearer pending lw shadows the ready ori and older W copy
      applyStimulus("ori6", 1, 1, 5'd1, 5'd0, 2'd1, 2'd3, 2'd1, 1, 5'd6, 0, 0, 0, 0, 0, 32'd2);
      applyStimulus("lw6", 1, 1, 5'd2, 5'd6, 2'd1, 2'd3, 2'd2, 1, 5'd6, 0, 0, 0, 0, 0, 32'd2);
      applyStimulus("sw_stall", 1, 1, 5'd6, 5'd7, 2'd1, 2'd2, 2'd0, 0, 5'd0, 1, 0, 0, 0, 2, 32'd2);
      applyStimulus("sw_go", 1, 1, 5'd6, 5'd7, 2'd1, 2'd2, 2'd0, 0, 5'd0, 0, 0, 0, 0, 0, 32'd3);
      idle("sw_E", 2'd3, 2'd0, 32'd3);
      idle("drain4", 2'd0, 2'd0, 32'd3);
      // writes to $0 never create a hazard or a forward
      applyStimulus("lw0", 1, 1, 5'd2, 5'd0, 2'd1, 2'd3, 2'd2, 1, 5'd0, 0, 0, 0, 0, 0, 32'd3);
      applyStimulus("read0", 1, 1, 5'd0, 5'd0, 2'd0, 2'd0, 2'd1, 1, 5'd8, 0, 0, 0, 0, 0, 32'd3);
      idle("drain5a", 2'd0, 2'd0, 32'd3);
      idle("drain5b", 2'd0, 2'd0, 32'd3);
      idle("drain5c", 2'd0, 2'd0, 32'd3);
      // reset asserted away from any clock edge while a stall is pending
      applyStimulus("lw5b", 1, 1, 5'd2, 5'd5, 2'd1, 2'd3, 2'd2, 1, 5'd5, 0, 0, 0, 0, 0, 32'd3);
      applyStimulus("beq_b", 1, 1, 5'd5, 5'd0, 2'd0, 2'd0, 2'd0, 0, 5'd0, 1, 0, 0, 0, 0, 32'd3);
      applyStimulus("async_rst", 0, 1, 5'd5, 5'd0, 2'd0, 2'd0, 2'd0, 0, 5'd0, 0, 0, 0, 0, 0, 32'd0);
      applyStimulus("post_rst", 1, 1, 5'd5, 5'd0, 2'd0, 2'd0, 2'd0, 0, 5'd0, 0, 0, 0, 0, 0, 32'd0);
      idle("final", 2'd0, 2'd0, 32'd0);

      for (int i = 0; i < 5 && exp_q.size() > 0; i++) @(negedge clk);
      #4;
      if (exp_q.size() > 0) begin
         errors++;
         $display("[TB] FAIL drain actual=%0d required=0", exp_q.size());
      end
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
